// File: rtl/serial_mag_comparator_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: FSM encoding and default width.
package serial_mag_comparator_pkg;

    localparam int unsigned DEFAULT_N = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_mag_comparator_cmp1.sv
// Single-bit magnitude compare cell: classifies one bit pair as greater, equal or less.
module comparator1bit (
    input  logic a,
    input  logic b,
    output logic agb,
    output logic aeb,
    output logic alb
);

    assign agb = a & ~b;
    assign aeb = ~(a ^ b);
    assign alb = ~a & b;

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator: walks operands MSB-first over N cycles and
// reports a one-hot registered A>B / A==B / A<B result with a single-cycle done pulse.
module serial_mag_comparator
    import serial_mag_comparator_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    output logic         busy,
    output logic         done,
    output logic         agb,
    output logic         aeb,
    output logic         alb
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    state_t          r_state;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [CW-1:0]   r_cnt;
    logic            r_decided;
    logic            r_gt;
    logic            r_lt;
    logic            r_busy;
    logic            r_done;
    logic            r_agb;
    logic            r_aeb;
    logic            r_alb;

    logic            w_bit_agb;
    logic            w_bit_aeb;
    logic            w_bit_alb;
    logic            w_accept;

    comparator1bit u_cmp (
        .a   (r_a[N-1]),
        .b   (r_b[N-1]),
        .agb (w_bit_agb),
        .aeb (w_bit_aeb),
        .alb (w_bit_alb)
    );

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));

    // Results are published from the DONE cycle, so done lands one edge after the last bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_agb     <= 1'b0;
            r_aeb     <= 1'b0;
            r_alb     <= 1'b0;
        end else begin
            r_done <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_state <= IDLE;
                end
                SHIFT: begin
                    r_a <= {r_a[N-2:0], 1'b0};
                    r_b <= {r_b[N-2:0], 1'b0};
                    // First differing bit pair decides; later pairs are ignored.
                    if (!r_decided && !w_bit_aeb) begin
                        r_decided <= 1'b1;
                        r_gt      <= w_bit_agb;
                        r_lt      <= w_bit_alb;
                    end
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_agb   <= r_gt;
                    r_aeb   <= ~r_decided;
                    r_alb   <= r_lt;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Acceptance overrides the state transition above, enabling back-to-back runs.
            if (w_accept) begin
                r_state   <= SHIFT;
                r_a       <= a_in;
                r_b       <= b_in;
                r_cnt     <= CW'(N - 1);
                r_decided <= 1'b0;
                r_gt      <= 1'b0;
                r_lt      <= 1'b0;
                r_busy    <= 1'b1;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign agb  = r_agb;
    assign aeb  = r_aeb;
    assign alb  = r_alb;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Self-checking bench for serial_mag_comparator using a scoreboard of expected results.
module tb_serial_mag_comparator;

    localparam int unsigned N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic         busy;
    logic         done;
    logic         agb;
    logic         aeb;
    logic         alb;

    int n_pass;
    int n_total;
    logic [2:0] sb[$];

    serial_mag_comparator #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .agb   (agb),
        .aeb   (aeb),
        .alb   (alb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    function automatic logic [2:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
        return {a > b, a == b, a < b};
    endfunction

    task automatic drive_start(input logic [N-1:0] a, input logic [N-1:0] b, input bit expect_accept);
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (expect_accept) sb.push_back(model(a, b));
    endtask

    // Waits for done; lat = edges after the accepting edge, -1 if it never came.
    task automatic wait_done(output int lat, output int nbusy, output bit moved);
        logic [2:0] held;
        lat   = -1;
        nbusy = 0;
        moved = 1'b0;
        held  = 3'b000;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) held = {agb, aeb, alb};
            if (busy) nbusy++;
            if (done) begin
                lat = i - 1;
                break;
            end
            if ({agb, aeb, alb} !== held) moved = 1'b1;
        end
    endtask

    task automatic count_done(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
    endtask

    task automatic test_reset;
        int lat, nb;
        bit mv;
        logic [2:0] exp;
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({busy, done, agb, aeb, alb} !== 5'b00000)
            $display("FAIL reset_outputs: got %b expected 00000", {busy, done, agb, aeb, alb});
        else n_pass++;
        // Start presented in the same cycle rst drops: first edge must accept it.
        rst   = 1'b0;
        start = 1'b1;
        a_in  = 8'h12;
        b_in  = 8'h34;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back(model(8'h12, 8'h34));
        wait_done(lat, nb, mv);
        n_total++;
        if (lat !== 9) $display("FAIL first_after_reset_latency: got %0d expected 9", lat);
        else n_pass++;
        exp = (sb.size() > 0) ? sb.pop_front() : 3'b000;
        n_total++;
        if ({agb, aeb, alb} !== exp) $display("FAIL first_after_reset_result: got %b expected %b", {agb, aeb, alb}, exp);
        else n_pass++;
    endtask

    task automatic test_greater;
        int lat, nb;
        bit mv;
        logic [2:0] exp;
        drive_start(8'hA5, 8'h3C, 1'b1);
        wait_done(lat, nb, mv);
        n_total++;
        if (nb !== 8) $display("FAIL gt_busy_cycles: got %0d expected 8", nb);
        else n_pass++;
        n_total++;
        if (lat !== 9) $display("FAIL gt_latency: got %0d expected 9", lat);
        else n_pass++;
        exp = (sb.size() > 0) ? sb.pop_front() : 3'b000;
        n_total++;
        if ({agb, aeb, alb} !== exp || exp !== 3'b100)
            $display("FAIL gt_result: got %b expected %b", {agb, aeb, alb}, exp);
        else n_pass++;
        n_total++;
        if (mv !== 1'b0) $display("FAIL gt_results_held: got moved=%0b expected 0", mv);
        else n_pass++;
    endtask

    task automatic test_first_bit;
        int lat, nb;
        bit mv;
        logic [2:0] exp;
        drive_start(8'h7F, 8'h80, 1'b1);
        wait_done(lat, nb, mv);
        n_total++;
        if (lat !== 9) $display("FAIL msb_latency: got %0d expected 9", lat);
        else n_pass++;
        exp = (sb.size() > 0) ? sb.pop_front() : 3'b000;
        n_total++;
        if ({agb, aeb, alb} !== exp || exp !== 3'b001)
            $display("FAIL msb_result: got %b expected %b", {agb, aeb, alb}, exp);
        else n_pass++;
        n_total++;
        if (mv !== 1'b0) $display("FAIL msb_results_held: got moved=%0b expected 0", mv);
        else n_pass++;
    endtask

    task automatic test_equal;
        int lat, nb;
        bit mv;
        logic [2:0] exp;
        logic [N-1:0] vals [2];
        vals[0] = 8'h5A;
        vals[1] = 8'h00;
        for (int k = 0; k < 2; k++) begin
            drive_start(vals[k], vals[k], 1'b1);
            wait_done(lat, nb, mv);
            exp = (sb.size() > 0) ? sb.pop_front() : 3'b000;
            n_total++;
            if ({agb, aeb, alb} !== exp || lat !== 9)
                $display("FAIL eq_result_%0d: got %b lat %0d expected %b lat 9", k, {agb, aeb, alb}, lat, exp);
            else n_pass++;
            n_total++;
            if ($countones({agb, aeb, alb}) !== 1)
                $display("FAIL eq_onehot_%0d: got %b expected exactly one bit", k, {agb, aeb, alb});
            else n_pass++;
        end
    endtask

    task automatic test_lsb;
        int lat, nb;
        bit mv;
        logic [2:0] exp;
        drive_start(8'h01, 8'h00, 1'b1);
        wait_done(lat, nb, mv);
        n_total++;
        if (lat !== 9) $display("FAIL lsb_latency: got %0d expected 9", lat);
        else n_pass++;
        exp = (sb.size() > 0) ? sb.pop_front() : 3'b000;
        n_total++;
        if ({agb, aeb, alb} !== exp || exp !== 3'b100)
            $display("FAIL lsb_result: got %b expected %b", {agb, aeb, alb}, exp);
        else n_pass++;
    endtask

    task automatic test_ignore_start;
        int lat, nb, seen;
        bit mv;
        logic [2:0] exp;
        drive_start(8'h10, 8'h20, 1'b1);
        repeat (3) @(negedge clk);
        start = 1'b1;
        a_in  = 8'hF0;
        b_in  = 8'h01;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, nb, mv);
        // Counted from the ignored start edge, which is 3 edges after acceptance.
        n_total++;
        if (lat !== 6) $display("FAIL ignore_latency: got %0d expected 6", lat);
        else n_pass++;
        exp = (sb.size() > 0) ? sb.pop_front() : 3'b000;
        n_total++;
        if ({agb, aeb, alb} !== exp || exp !== 3'b001)
            $display("FAIL ignore_result: got %b expected %b", {agb, aeb, alb}, exp);
        else n_pass++;
        count_done(12, seen);
        n_total++;
        if (seen !== 0) $display("FAIL ignore_extra_done: got %0d pulses expected 0", seen);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int lat, nb;
        bit mv, fell;
        logic [2:0] exp;
        drive_start(8'hC3, 8'hC4, 1'b1);
        fell = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) begin
                fell = 1'b1;
                break;
            end
        end
        n_total++;
        if (fell !== 1'b1) $display("FAIL b2b_busy_fall: got busy stuck expected fall");
        else n_pass++;
        start = 1'b1;
        a_in  = 8'h99;
        b_in  = 8'h11;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb.push_back(model(8'h99, 8'h11));
        @(negedge clk);
        n_total++;
        if ({done, busy} !== 2'b11) $display("FAIL b2b_done_busy: got %b expected 11", {done, busy});
        else n_pass++;
        exp = (sb.size() > 0) ? sb.pop_front() : 3'b000;
        n_total++;
        if ({agb, aeb, alb} !== exp || exp !== 3'b001)
            $display("FAIL b2b_first_result: got %b expected %b", {agb, aeb, alb}, exp);
        else n_pass++;
        wait_done(lat, nb, mv);
        n_total++;
        if (lat !== 8) $display("FAIL b2b_second_latency: got %0d expected 8 after first done", lat);
        else n_pass++;
        exp = (sb.size() > 0) ? sb.pop_front() : 3'b000;
        n_total++;
        if ({agb, aeb, alb} !== exp || exp !== 3'b100)
            $display("FAIL b2b_second_result: got %b expected %b", {agb, aeb, alb}, exp);
        else n_pass++;
        n_total++;
        if (mv !== 1'b0) $display("FAIL b2b_results_held: got moved=%0b expected 0", mv);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int lat, nb, seen;
        bit mv;
        logic [2:0] exp;
        drive_start(8'hFF, 8'h00, 1'b0);
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({busy, done, agb, aeb, alb} !== 5'b00000)
            $display("FAIL midrst_outputs: got %b expected 00000", {busy, done, agb, aeb, alb});
        else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        count_done(12, seen);
        n_total++;
        if (seen !== 0) $display("FAIL midrst_no_done: got %0d pulses expected 0", seen);
        else n_pass++;
        drive_start(8'h33, 8'h44, 1'b1);
        wait_done(lat, nb, mv);
        n_total++;
        if (lat !== 9) $display("FAIL midrst_fresh_latency: got %0d expected 9", lat);
        else n_pass++;
        exp = (sb.size() > 0) ? sb.pop_front() : 3'b000;
        n_total++;
        if ({agb, aeb, alb} !== exp || exp !== 3'b001)
            $display("FAIL midrst_fresh_result: got %b expected %b", {agb, aeb, alb}, exp);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_greater();
        test_first_bit();
        test_equal();
        test_lsb();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        n_total++;
        if (sb.size() !== 0) $display("FAIL scoreboard_drained: got %0d left expected 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_mag_comparator.md
SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

Interface
REQ-001 SHALL have parameter N, default 8, meaning operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to load operands and begin comparison; sampled on clk rising edge.
REQ-005 SHALL have port a_in  input  N  operand A, unsigned; sampled only in the cycle start is accepted.
REQ-006 SHALL have port b_in  input  N  operand B, unsigned; sampled only in the cycle start is accepted.
REQ-007 SHALL have port busy  output  1  high while a comparison is in progress.
REQ-008 SHALL have port done  output  1  single-cycle pulse marking valid results.
REQ-009 SHALL have port agb  output  1  registered result A > B.
REQ-010 SHALL have port aeb  output  1  registered result A == B.
REQ-011 SHALL have port alb  output  1  registered result A < B.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 SHALL accept start only in IDLE or DONE; on acceptance load a_in/b_in into shift registers, clear the decided flag, set the bit counter to N-1, and enter SHIFT.
REQ-014 SHALL ignore start while in SHIFT, without disturbing the operation in progress.
REQ-015 SHALL, in SHIFT, present the MSB of each shift register to a 1-bit compare cell once per cycle, then shift both registers left by one.
REQ-016 SHALL latch gt/lt from the first cycle whose bit pair differs, set the decided flag, and ignore all later bit pairs.
REQ-017 SHALL always run exactly N SHIFT cycles, with no early exit on a decision.
REQ-018 SHALL, after the SHIFT cycle with counter 0, enter DONE and register agb/aeb/alb; aeb=1 iff no differing bit pair was seen.
REQ-019 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE unless start is accepted in that cycle.
REQ-020 SHALL set done and the new results visible N+1 cycles after the accepting edge: start accepted at edge k gives done high after edge k+N+1.
REQ-021 SHALL hold agb/aeb/alb stable from DONE until the next DONE, including throughout the following SHIFT phase.
REQ-022 SHALL keep exactly one of agb/aeb/alb high after any completed comparison.
REQ-023 SHALL drive busy high in SHIFT only.
REQ-024 SHALL, on a start accepted in DONE, pulse done normally in that cycle and then enter SHIFT directly (back-to-back operation).

Reset
REQ-025 SHALL, while rst is high, force state IDLE, and busy, done, agb, aeb, alb, the shift registers, the counter, and the decided flag all to 0, regardless of clk.
REQ-026 SHALL abort any comparison when rst asserts mid-operation, with no done pulse and results cleared to 0.
REQ-027 SHALL accept start on the first rising edge after rst deasserts.

Structure
REQ-028 SHALL place the FSM state encoding (2-bit: IDLE=0, SHIFT=1, DONE=2) and the default width constant in a shared package.
REQ-029 SHALL instantiate the existing 1-bit compare cell comparator1bit (ports a, b, agb, aeb, alb) as its single sub-module for the per-bit decision.

Verification
REQ-030 SHALL verify: N=8, A=0xA5, B=0x3C, start 1 cycle -> busy high for 8 cycles, done pulse at edge k+9, agb=1, aeb=0, alb=0.
REQ-031 SHALL verify: A=0x7F, B=0x80 -> alb=1, and the decision made on the first bit is held through all 8 cycles.
REQ-032 SHALL verify: A=B=0x5A, then A=B=0x00 -> aeb=1 in both cases, with exactly one result bit high.
REQ-033 SHALL verify: start re-asserted during SHIFT with different operands -> ignored, and the original result is reported; start in the DONE cycle -> second comparison completes 9 cycles later.
REQ-034 SHALL verify: rst asserted asynchronously mid-SHIFT (cycle 4) -> outputs 0 immediately, no done, and a fresh start afterwards completes correctly.
REQ-035 SHALL verify: A=0x01, B=0x00 (difference only in the LSB) -> agb=1 with done at edge k+9.
